// File: rtl/instr_loader.sv
// ============================================================================
// instr_loader
// ----------------------------------------------------------------------------
// Producer side of the instruction-memory write port. A program arrives as a
// byte stream from the host/boot path. Bytes are packed little-endian into a
// write window of WR_BYTES bytes and handed to the instruction memory
// controller as one write. The controller advances its write pointer by
// write_pointer_shift_minusone+1 bytes for each write it accepts.
//
// Handshakes:
//   Byte stream   : a byte moves on every rising edge where s_valid && s_ready.
//                   While s_ready is low the host holds s_data/s_last stable.
//   Memory write  : a write retires on every rising edge where we && wr_ready.
//                   While we is high, wr_data and shift stay constant.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   start                         pulse: begin a new load (honoured in IDLE/DONE)
//   s_data, s_valid, s_last       program byte stream in; s_ready back-pressure
//   we, write_pointer_shift_minusone, wr_data   write request to memory
//   wr_ready                      memory accepts the pending write
//   load_done                     program fully written, held until next start
//   load_overflow                 sticky: program was longer than MAX_BYTES
//   bytes_loaded                  bytes committed to memory so far
//
// MAX_BYTES is expected to be a whole number of write windows, which holds
// for any instruction BRAM sized as depth * width/8.
// ============================================================================
module instr_loader #(
    parameter int LOG_WR_WIN = 3,
    parameter int WR_WIDTH   = 64,
    parameter int MAX_BYTES  = 1024,
    parameter int CNT_W      = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [7:0]            s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic                  we,
    output logic [LOG_WR_WIN-1:0] write_pointer_shift_minusone,
    output logic [WR_WIDTH-1:0]   wr_data,
    input  logic                  wr_ready,
    output logic                  load_done,
    output logic                  load_overflow,
    output logic [CNT_W-1:0]      bytes_loaded
);

    localparam int                  WR_BYTES = 2 ** LOG_WR_WIN;
    localparam logic [LOG_WR_WIN:0] WIN_FULL = WR_BYTES[LOG_WR_WIN:0];
    localparam logic [CNT_W:0]      MAX_LIM  = MAX_BYTES[CNT_W:0];

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state, state_n;
    logic [LOG_WR_WIN:0]   cnt, cnt_n;          // bytes in the current window
    logic                  win_last, win_last_n; // current window holds s_last
    logic                  s_ready_n;
    logic                  we_n;
    logic [LOG_WR_WIN-1:0] shift_n;
    logic [WR_WIDTH-1:0]   wr_data_n;
    logic                  load_done_n;
    logic                  load_overflow_n;
    logic [CNT_W-1:0]      bytes_loaded_n;

    logic                  accept;
    logic [LOG_WR_WIN:0]   cnt_inc;
    logic [CNT_W:0]        fill_total;          // committed + buffered bytes

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                        <= S_IDLE;
            cnt                          <= '0;
            win_last                     <= 1'b0;
            s_ready                      <= 1'b0;
            we                           <= 1'b0;
            write_pointer_shift_minusone <= '0;
            wr_data                      <= '0;
            load_done                    <= 1'b0;
            load_overflow                <= 1'b0;
            bytes_loaded                 <= '0;
        end else begin
            state                        <= state_n;
            cnt                          <= cnt_n;
            win_last                     <= win_last_n;
            s_ready                      <= s_ready_n;
            we                           <= we_n;
            write_pointer_shift_minusone <= shift_n;
            wr_data                      <= wr_data_n;
            load_done                    <= load_done_n;
            load_overflow                <= load_overflow_n;
            bytes_loaded                 <= bytes_loaded_n;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and next-output logic. Every output is registered, so the
    // values computed here appear one cycle after the deciding edge.
    // ------------------------------------------------------------------------
    always_comb begin
        state_n         = state;
        cnt_n           = cnt;
        win_last_n      = win_last;
        s_ready_n       = s_ready;
        we_n            = we;
        shift_n         = write_pointer_shift_minusone;
        wr_data_n       = wr_data;
        load_done_n     = load_done;
        load_overflow_n = load_overflow;
        bytes_loaded_n  = bytes_loaded;

        accept     = s_valid && s_ready;
        cnt_inc    = cnt + (LOG_WR_WIN + 1)'(1);
        fill_total = {1'b0, bytes_loaded} + {{(CNT_W - LOG_WR_WIN){1'b0}}, cnt};

        case (state)
            S_IDLE, S_DONE: begin
                s_ready_n = 1'b0;
                if (start) begin
                    bytes_loaded_n  = '0;
                    load_done_n     = 1'b0;
                    load_overflow_n = 1'b0;
                    cnt_n           = '0;
                    win_last_n      = 1'b0;
                    wr_data_n       = '0;
                    s_ready_n       = 1'b1;
                    state_n         = S_FILL;
                end
            end

            S_FILL: begin
                if (accept) begin
                    if (load_overflow || fill_total == MAX_LIM) begin
                        // Memory is full: drop the byte and keep draining
                        // the stream so the host is never stalled forever.
                        load_overflow_n = 1'b1;
                        if (s_last) begin
                            s_ready_n   = 1'b0;
                            load_done_n = 1'b1;
                            state_n     = S_DONE;
                        end
                    end else begin
                        for (int i = 0; i < WR_BYTES; i++) begin
                            if (cnt[LOG_WR_WIN-1:0] == i[LOG_WR_WIN-1:0]) begin
                                wr_data_n[8*i +: 8] = s_data;
                            end
                        end
                        cnt_n = cnt_inc;
                        if (cnt_inc == WIN_FULL || s_last) begin
                            // cnt is the old count, i.e. final count minus one
                            shift_n    = cnt[LOG_WR_WIN-1:0];
                            win_last_n = s_last;
                            s_ready_n  = 1'b0;
                            we_n       = 1'b1;
                            state_n    = S_WRITE;
                        end
                    end
                end
            end

            S_WRITE: begin
                if (wr_ready) begin
                    we_n           = 1'b0;
                    bytes_loaded_n = bytes_loaded
                                   + CNT_W'(write_pointer_shift_minusone)
                                   + CNT_W'(1);
                    cnt_n          = '0;
                    wr_data_n      = '0;
                    win_last_n     = 1'b0;
                    if (win_last) begin
                        load_done_n = 1'b1;
                        state_n     = S_DONE;
                    end else begin
                        s_ready_n = 1'b1;
                        state_n   = S_FILL;
                    end
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_loader.sv
// ============================================================================
// tb_instr_loader
// Directed and randomized program loads into instr_loader (MAX_BYTES = 16 so
// the overflow path is reachable). A reference model derives the expected
// list of memory writes from the byte list: the first min(n, MAX_BYTES)
// bytes cut into 8-byte chunks, packed little-endian, shift = chunk length-1.
// ============================================================================
module tb_instr_loader;

    localparam int LOG_WR_WIN = 3;
    localparam int WR_WIDTH   = 64;
    localparam int MAXB       = 16;
    localparam int CNT_W      = 5;
    localparam int WR_BYTES   = 8;

    localparam int MODE_READY  = 0;  // wr_ready always high
    localparam int MODE_RANDOM = 1;  // wr_ready random every cycle
    localparam int MODE_STALL5 = 2;  // wr_ready low for 5 cycles after we rises

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic                  start;
    logic [7:0]            s_data;
    logic                  s_valid;
    logic                  s_last;
    logic                  s_ready;
    logic                  we;
    logic [LOG_WR_WIN-1:0] shift;
    logic [WR_WIDTH-1:0]   wr_data;
    logic                  wr_ready;
    logic                  load_done;
    logic                  load_overflow;
    logic [CNT_W-1:0]      bytes_loaded;

    instr_loader #(
        .LOG_WR_WIN (LOG_WR_WIN),
        .WR_WIDTH   (WR_WIDTH),
        .MAX_BYTES  (MAXB),
        .CNT_W      (CNT_W)
    ) dut (
        .clk                          (clk),
        .rst_n                        (rst_n),
        .start                        (start),
        .s_data                       (s_data),
        .s_valid                      (s_valid),
        .s_last                       (s_last),
        .s_ready                      (s_ready),
        .we                           (we),
        .write_pointer_shift_minusone (shift),
        .wr_data                      (wr_data),
        .wr_ready                     (wr_ready),
        .load_done                    (load_done),
        .load_overflow                (load_overflow),
        .bytes_loaded                 (bytes_loaded)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    logic [7:0]            prog_q[$];
    logic [WR_WIDTH-1:0]   exp_q[$];
    logic [LOG_WR_WIN-1:0] exp_shift_q[$];
    logic [WR_WIDTH-1:0]   got_q[$];
    logic [LOG_WR_WIN-1:0] got_shift_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: expected writes for the bytes in prog_q.
    task automatic build_expected(output int kept);
        logic [WR_WIDTH-1:0] w;
        int len;
        exp_q.delete();
        exp_shift_q.delete();
        kept = (prog_q.size() < MAXB) ? prog_q.size() : MAXB;
        for (int base = 0; base < kept; base += WR_BYTES) begin
            len = (kept - base < WR_BYTES) ? (kept - base) : WR_BYTES;
            w = '0;
            for (int j = 0; j < len; j++) w[8*j +: 8] = prog_q[base + j];
            exp_q.push_back(w);
            exp_shift_q.push_back(LOG_WR_WIN'(len - 1));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_start(input string tag);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_start_s_ready"},   64'(s_ready), 64'(1));
        chk({tag, "_start_done"},      64'(load_done), 64'(0));
        chk({tag, "_start_overflow"},  64'(load_overflow), 64'(0));
        chk({tag, "_start_bytes"},     64'(bytes_loaded), 64'(0));
        chk({tag, "_start_we"},        64'(we), 64'(0));
    endtask

    // Streams prog_q into the DUT, captures every retired write and checks
    // the result against the reference model.
    task automatic run_program(input string tag, input int mode, input int valid_pct);
        int n, kept, idx, cyc, k, stall;
        logic acc_prev, prev_stall, exp_we_next, prev_we;
        logic [WR_WIDTH-1:0]   prev_data;
        logic [LOG_WR_WIN-1:0] prev_shift;
        int nw;

        build_expected(kept);
        got_q.delete();
        got_shift_q.delete();
        n = prog_q.size();
        idx = 0; cyc = 0; stall = 0;
        acc_prev = 1'b0; prev_stall = 1'b0; exp_we_next = 1'b0; prev_we = 1'b0;
        prev_data = '0; prev_shift = '0;
        s_valid = 1'b0;

        while (!(load_done === 1'b1 && idx == n) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (prev_stall) begin
                chk({tag, "_hold_we"},      64'(we), 64'(1));
                chk({tag, "_hold_data"},    wr_data, prev_data);
                chk({tag, "_hold_shift"},   64'(shift), 64'(prev_shift));
                chk({tag, "_hold_s_ready"}, 64'(s_ready), 64'(0));
            end
            if (exp_we_next) chk({tag, "_we_latency"}, 64'(we), 64'(1));
            exp_we_next = 1'b0;

            case (mode)
                MODE_READY:  wr_ready = 1'b1;
                MODE_RANDOM: wr_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (we === 1'b1 && !prev_we) stall = 5;
                    if (stall > 0) begin
                        wr_ready = 1'b0;
                        stall--;
                    end else begin
                        wr_ready = 1'b1;
                    end
                end
            endcase
            prev_we = (we === 1'b1);
            if (we === 1'b1 && wr_ready) begin
                got_q.push_back(wr_data);
                got_shift_q.push_back(shift);
            end
            prev_stall = (we === 1'b1) && !wr_ready;
            prev_data  = wr_data;
            prev_shift = shift;

            if (acc_prev) s_valid = 1'b0;
            acc_prev = 1'b0;
            if (!s_valid && idx < n && $urandom_range(1, 100) <= valid_pct) begin
                s_valid = 1'b1;
                s_data  = prog_q[idx];
                s_last  = (idx == n - 1);
            end
            if (s_valid && s_ready === 1'b1) begin
                k = idx + 1;
                exp_we_next = (k <= MAXB) && ((k % WR_BYTES == 0) || (k == n));
                idx++;
                acc_prev = 1'b1;
            end
        end
        s_valid  = 1'b0;
        s_last   = 1'b0;
        wr_ready = 1'b0;

        chk({tag, "_accepted"},     64'(idx), 64'(n));
        chk({tag, "_load_done"},    64'(load_done), 64'(1));
        chk({tag, "_overflow"},     64'(load_overflow), 64'(n > MAXB));
        chk({tag, "_bytes_loaded"}, 64'(bytes_loaded), 64'(kept));
        chk({tag, "_s_ready_idle"}, 64'(s_ready), 64'(0));
        chk({tag, "_we_idle"},      64'(we), 64'(0));
        chk({tag, "_write_count"},  64'(got_q.size()), 64'(exp_q.size()));
        nw = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < nw; i++) begin
            chk($sformatf("%s_wr_data%0d", tag, i), got_q[i], exp_q[i]);
            chk($sformatf("%s_shift%0d", tag, i), 64'(got_shift_q[i]), 64'(exp_shift_q[i]));
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int idx;
        int n;
        rst_n    = 1'b0;
        start    = 1'b0;
        s_data   = '0;
        s_valid  = 1'b0;
        s_last   = 1'b0;
        wr_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_s_ready",  64'(s_ready), 64'(0));
        chk("rst_we",       64'(we), 64'(0));
        chk("rst_done",     64'(load_done), 64'(0));
        chk("rst_overflow", 64'(load_overflow), 64'(0));
        chk("rst_wr_data",  wr_data, 64'(0));
        chk("rst_shift",    64'(shift), 64'(0));
        chk("rst_bytes",    64'(bytes_loaded), 64'(0));
        rst_n = 1'b1;

        // Reset while a write is pending and memory is not ready.
        do_start("t1");
        idx = 0;
        for (int c = 0; c < 40 && we !== 1'b1; c++) begin
            @(negedge clk);
            s_valid = (idx < WR_BYTES);
            s_data  = 8'(idx + 8'h40);
            s_last  = 1'b0;
            if (s_valid && s_ready === 1'b1) idx++;
        end
        s_valid = 1'b0;
        chk("t1_we_pending", 64'(we), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("t1_async_we",       64'(we), 64'(0));
        chk("t1_async_s_ready",  64'(s_ready), 64'(0));
        chk("t1_async_wr_data",  wr_data, 64'(0));
        chk("t1_async_shift",    64'(shift), 64'(0));
        chk("t1_async_done",     64'(load_done), 64'(0));
        chk("t1_async_overflow", 64'(load_overflow), 64'(0));
        chk("t1_async_bytes",    64'(bytes_loaded), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t1_idle_s_ready", 64'(s_ready), 64'(0));

        // 16 bytes 0x00..0x0F, memory always ready.
        prog_q.delete();
        for (int i = 0; i < 16; i++) prog_q.push_back(8'(i));
        do_start("t2");
        run_program("t2", MODE_READY, 100);
        if (got_q.size() == 2) begin
            chk("t2_word0_const", got_q[0], 64'h0706050403020100);
            chk("t2_word1_const", got_q[1], 64'h0F0E0D0C0B0A0908);
        end

        // Short program: one partial window.
        prog_q.delete();
        prog_q.push_back(8'hAA);
        prog_q.push_back(8'hBB);
        prog_q.push_back(8'hCC);
        do_start("t3");
        run_program("t3", MODE_READY, 100);
        if (got_q.size() == 1) chk("t3_word_const", got_q[0], 64'h0000000000CCBBAA);

        // Full window with memory back-pressure.
        prog_q.delete();
        for (int i = 0; i < 8; i++) prog_q.push_back(8'($urandom_range(0, 255)));
        do_start("t4");
        run_program("t4", MODE_STALL5, 100);

        // Overflow: 20 bytes into a 16-byte memory.
        prog_q.delete();
        for (int i = 0; i < 20; i++) prog_q.push_back(8'($urandom_range(0, 255)));
        do_start("t5");
        run_program("t5", MODE_RANDOM, 70);

        // Restart after an overflowed load.
        prog_q.delete();
        for (int i = 0; i < 8; i++) prog_q.push_back(8'($urandom_range(0, 255)));
        do_start("t6");
        run_program("t6", MODE_RANDOM, 80);

        // Random programs, lengths around and past capacity.
        for (int r = 0; r < 10; r++) begin
            prog_q.delete();
            n = $urandom_range(1, 22);
            for (int i = 0; i < n; i++) prog_q.push_back(8'($urandom_range(0, 255)));
            do_start($sformatf("r%0d", r));
            run_program($sformatf("r%0d", r), $urandom_range(0, 2), $urandom_range(40, 100));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
